// File: rtl/fifo_pack_pkg.sv
// Shared widths, flag positions and entry type for the word-packing FIFO.
// Each entry holds four 16-bit lanes plus the partial and last flags.
package fifo_pack_pkg;

   localparam int LANE_W      = 16;
   localparam int LANES       = 4;
   localparam int LAST_BIT    = 64;
   localparam int PARTIAL_BIT = 65;
   localparam int ENTRY_W     = LANES * LANE_W + 2;

   typedef logic [ENTRY_W-1:0] entry_t;

   typedef enum logic {
      WR_LANE  = 1'b0,
      WR_ENTRY = 1'b1
   } wr_mode_e;

endpackage

// File: rtl/fifo_pack_mem.sv
// Entry storage for the packing FIFO.
// Supports whole-entry or single-lane writes, and has a combinational read port.
module fifo_pack_mem
   import fifo_pack_pkg::*;
#(
   parameter int fifoDepthLog2 = 1
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  wr_mode_e                 i_mode,
   input  logic                     i_flagWe,
   input  logic [1:0]               i_laneSel,
   input  logic [fifoDepthLog2-1:0] i_wrIdx,
   input  entry_t                   i_wrData,
   input  logic [fifoDepthLog2-1:0] i_rdIdx,
   output entry_t                   o_rdData
);

   entry_t r_mem [1<<fifoDepthLog2];

   // Storage is deliberately left without a reset.
   // The controller's whole-entry write on word 0 hides any stale contents.
   always_ff @(posedge clk) begin
      if (i_we) begin
         if (i_mode == WR_ENTRY) begin
            r_mem[i_wrIdx] <= i_wrData;
         end else begin
            r_mem[i_wrIdx][{i_laneSel, 4'b0000} +: LANE_W] <= i_wrData[{i_laneSel, 4'b0000} +: LANE_W];
            if (i_flagWe) begin
               r_mem[i_wrIdx][PARTIAL_BIT:LAST_BIT] <= i_wrData[PARTIAL_BIT:LAST_BIT];
            end
         end
      end
   end

   assign o_rdData = r_mem[i_rdIdx];

endmodule

// File: rtl/fifo_pack_ctrl.sv
// Packs 16-bit words into 66-bit entries and manages the write, read and word pointers.
// Completed entries are presented on a registered valid/ready output port.
module fifo_pack_ctrl
   import fifo_pack_pkg::*;
#(
   parameter int fifoDepthLog2 = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANE_W-1:0]      in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ENTRY_W-1:0]     out_data,
   output logic [fifoDepthLog2:0] level
);

   logic [fifoDepthLog2:0] r_wrPtr;
   logic [fifoDepthLog2:0] r_rdPtr;
   logic [1:0]             r_wordPtr;
   logic                   r_outValid;
   entry_t                 r_outData;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_accept;
   logic                   w_closing;
   logic                   w_load;
   logic [1:0]             w_flags;
   wr_mode_e               w_mode;
   entry_t                 w_wrData;
   entry_t                 w_rdData;

   assign w_empty   = (r_wrPtr == r_rdPtr);
   assign w_full    = (r_wrPtr[fifoDepthLog2-1:0] == r_rdPtr[fifoDepthLog2-1:0]) &&
                      (r_wrPtr[fifoDepthLog2] != r_rdPtr[fifoDepthLog2]);
   assign in_ready  = !w_full && !flush;
   assign w_accept  = in_valid && in_ready;
   assign w_closing = (r_wordPtr == 2'd3) || in_last;
   assign w_load    = !w_empty && (!r_outValid || out_ready);

   // The first word places itself in the top lane and zeroes everything else.
   // That write is what clears stale lanes left in a reused slot.
   always_comb begin
      w_flags  = w_closing ? {(r_wordPtr != 2'd3), in_last} : 2'b00;
      w_mode   = (r_wordPtr == 2'd0) ? WR_ENTRY : WR_LANE;
      w_wrData = {w_flags, {LANES{in_data}}};
      if (w_mode == WR_ENTRY) begin
         w_wrData = {w_flags, in_data, {((LANES-1)*LANE_W){1'b0}}};
      end
   end

   fifo_pack_mem #(
      .fifoDepthLog2 (fifoDepthLog2)
   ) u_mem (
      .clk       (clk),
      .i_we      (w_accept),
      .i_mode    (w_mode),
      .i_flagWe  (w_closing),
      .i_laneSel (~r_wordPtr),
      .i_wrIdx   (r_wrPtr[fifoDepthLog2-1:0]),
      .i_wrData  (w_wrData),
      .i_rdIdx   (r_rdPtr[fifoDepthLog2-1:0]),
      .o_rdData  (w_rdData)
   );

   // The load decision looks at storage before this cycle's commit.
   // That lets a commit and a load happen together with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_wordPtr  <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
      end else if (flush) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_wordPtr  <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
      end else begin
         if (w_accept) begin
            if (w_closing) begin
               r_wrPtr   <= r_wrPtr + 1'b1;
               r_wordPtr <= 2'd0;
            end else begin
               r_wordPtr <= r_wordPtr + 2'd1;
            end
         end
         if (w_load) begin
            r_outData  <= w_rdData;
            r_outValid <= 1'b1;
            r_rdPtr    <= r_rdPtr + 1'b1;
         end else if (out_ready) begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign level     = r_wrPtr - r_rdPtr;

endmodule
